// File: rtl/raster_mem_pkg.sv
// Shared definitions for the rasterizer memory responder.
// Provides the FSM state enum, the port-id constants used to index the
// fb/zb request pair, the default bus widths and a small port helper.
package raster_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 24;
  localparam int unsigned DATA_W_DEF = 32;

  // Port ids double as bit positions in the arbiter request vector.
  localparam logic PORT_FB = 1'b0;
  localparam logic PORT_ZB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

  // The opposite initiator port.
  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/raster_mem_responder_if.sv
// Bus bundle between the rasterizer initiators, the responder and memory.
// fb_* / zb_*: req/we/addr/wdata from the initiator, rdata/ack/ready back.
// mem_*      : req/we/addr/wdata to the memory controller, rdata/ack back.
// slave  : responder view (answers fb/zb, drives mem commands).
// master : environment view (rasterizer initiators plus memory controller).
interface raster_mem_responder_if
  import raster_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              fb_req;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_wdata;
  logic [DATA_W-1:0] fb_rdata;
  logic              fb_ack;
  logic              fb_ready;

  logic              zb_req;
  logic              zb_we;
  logic [ADDR_W-1:0] zb_addr;
  logic [DATA_W-1:0] zb_wdata;
  logic [DATA_W-1:0] zb_rdata;
  logic              zb_ack;
  logic              zb_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  fb_req, fb_we, fb_addr, fb_wdata,
    output fb_rdata, fb_ack, fb_ready,
    input  zb_req, zb_we, zb_addr, zb_wdata,
    output zb_rdata, zb_ack, zb_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output fb_req, fb_we, fb_addr, fb_wdata,
    input  fb_rdata, fb_ack, fb_ready,
    output zb_req, zb_we, zb_addr, zb_wdata,
    input  zb_rdata, zb_ack, zb_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// Ports: clk, rst (sync, active-high); req[1:0] indexed by port id;
// update/upd_port record the port just served; gnt_valid_c/gnt_port_c
// give the combinational grant for the current request pattern.
// last_grant resets to fb so that zb wins the first tie.
module rr_arb2
  import raster_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_port,
  output logic       gnt_valid_c,
  output logic       gnt_port_c
);

  logic last_grant_q;
  logic last_grant_d;

  // Pointer update on the strobe only.
  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = upd_port;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_FB;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // On a tie the port not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_valid_c = |req;
    gnt_port_c  = PORT_FB;
    if (req[PORT_FB] && req[PORT_ZB]) begin
      gnt_port_c = other_port(last_grant_q);
    end else if (req[PORT_ZB]) begin
      gnt_port_c = PORT_ZB;
    end
  end

endmodule

// File: rtl/raster_mem_responder.sv
// Memory-side responder for the rasterizer fb and zb initiator ports.
// Merges both ports onto one memory port with round-robin arbitration and
// keeps a single transaction outstanding (IDLE -> MEM -> RESP -> IDLE).
// Ports: clk, rst (sync, active-high); bus (slave modport) carrying the
// fb_*, zb_* initiator handshakes and the mem_* command/response port.
module raster_mem_responder
  import raster_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  raster_mem_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_MEM  = MEM;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]        state_q,     state_d;
  logic              grant_q,     grant_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fb_ack_q,    fb_ack_d;
  logic              zb_ack_q,    zb_ack_d;
  logic [DATA_W-1:0] fb_rdata_q,  fb_rdata_d;
  logic [DATA_W-1:0] zb_rdata_q,  zb_rdata_d;

  logic arb_update_c;
  logic gnt_valid_c;
  logic gnt_port_c;

  // Arbiter sees raw requests; they are only acted on in IDLE, so a request
  // raised during MEM/RESP simply waits.
  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         ({bus.zb_req, bus.fb_req}),
    .update      (arb_update_c),
    .upd_port    (grant_q),
    .gnt_valid_c (gnt_valid_c),
    .gnt_port_c  (gnt_port_c)
  );

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fb_ack_d     = 1'b0;
    zb_ack_d     = 1'b0;
    fb_rdata_d   = fb_rdata_q;
    zb_rdata_d   = zb_rdata_q;
    arb_update_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid_c) begin
          grant_d   = gnt_port_c;
          mem_req_d = 1'b1;
          state_d   = S_MEM;
          if (gnt_port_c == PORT_ZB) begin
            mem_we_d    = bus.zb_we;
            mem_addr_d  = bus.zb_addr;
            mem_wdata_d = bus.zb_wdata;
          end else begin
            mem_we_d    = bus.fb_we;
            mem_addr_d  = bus.fb_addr;
            mem_wdata_d = bus.fb_wdata;
          end
        end
      end

      S_MEM: begin
        // Command fields stay put; only mem_req drops once memory answers.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_RESP;
          if (grant_q == PORT_ZB) begin
            zb_ack_d = 1'b1;
            if (!mem_we_q) begin
              zb_rdata_d = bus.mem_rdata;
            end
          end else begin
            fb_ack_d = 1'b1;
            if (!mem_we_q) begin
              fb_rdata_d = bus.mem_rdata;
            end
          end
        end
      end

      S_RESP: begin
        // ack is high for this single cycle; remember who was served.
        arb_update_c = 1'b1;
        state_d      = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= PORT_FB;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fb_ack_q    <= 1'b0;
      zb_ack_q    <= 1'b0;
      fb_rdata_q  <= '0;
      zb_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fb_ack_q    <= fb_ack_d;
      zb_ack_q    <= zb_ack_d;
      fb_rdata_q  <= fb_rdata_d;
      zb_rdata_q  <= zb_rdata_d;
    end
  end

  // ready is forced low while reset is asserted, even though state is IDLE.
  assign bus.fb_ready  = (state_q == S_IDLE) && !rst;
  assign bus.zb_ready  = (state_q == S_IDLE) && !rst;
  assign bus.fb_ack    = fb_ack_q;
  assign bus.zb_ack    = zb_ack_q;
  assign bus.fb_rdata  = fb_rdata_q;
  assign bus.zb_rdata  = zb_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
